// File: rtl/disp_pkg.sv
// Shared types and constants for the shared 4-digit 7-segment display controller.
//   disp_state_e : display owner (nobody, client A, client B)
//   digit_idx_t  : scan slot index, 0 = rightmost digit
//   ANODES_OFF   : all digits dark (anodes are active-low)
//   anode_sel()  : active-low one-hot anode pattern for a slot
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } disp_state_e;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] ANODES_OFF = 4'hF;

  // 120 Hz frame at 100 MHz with four slots per frame.
  localparam int unsigned REFRESH_DIV_DEFAULT = 208333;
  localparam int unsigned HOLD_FRAMES_DEFAULT = 30;

  function automatic logic [3:0] anode_sel(input digit_idx_t idx);
    logic [3:0] sel;
    sel      = ANODES_OFF;
    sel[idx] = 1'b0;
    return sel;
  endfunction

endpackage

// File: rtl/display_share_ctrl_if.sv
// Client/display bundle for display_share_ctrl.
//   en, req_*, digits_*, blank_* : driven by the clients (master)
//   gnt_*, anodes, hex_cur, frame_done : driven by the controller (slave)
interface display_share_ctrl_if;

  logic        en;
  logic        req_a;
  logic [15:0] digits_a;
  logic [3:0]  blank_a;
  logic        req_b;
  logic [15:0] digits_b;
  logic [3:0]  blank_b;
  logic        gnt_a;
  logic        gnt_b;
  logic [3:0]  anodes;
  logic [3:0]  hex_cur;
  logic        frame_done;

  modport master (
    output en, req_a, digits_a, blank_a, req_b, digits_b, blank_b,
    input  gnt_a, gnt_b, anodes, hex_cur, frame_done
  );

  modport slave (
    input  en, req_a, digits_a, blank_a, req_b, digits_b, blank_b,
    output gnt_a, gnt_b, anodes, hex_cur, frame_done
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and wraps.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   tick  : high for the single cycle in which the count is REFRESH_DIV-1
module scan_tick_gen
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_share_ctrl.sv
// Scan sequencer and two-client arbiter for a 4-digit 7-segment display.
// One client owns each whole frame; its digits and blanks are snapshotted at
// the frame boundary so a frame never tears. A contested owner yields after
// HOLD_FRAMES frames; A wins simultaneous first requests.
//   clk, rst_n        : system clock, asynchronous active-low reset
//   bus.en            : display enable (only blanks the anodes when low)
//   bus.req_/digits_/blank_{a,b} : client requests, hex digits, per-digit blanks
//   bus.gnt_{a,b}     : owner of the current frame
//   bus.anodes        : active-low digit enables, bit0 = rightmost
//   bus.hex_cur       : nibble of the active digit, to the segment decoder
//   bus.frame_done    : one-cycle pulse following each frame boundary
module display_share_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT,
  parameter int unsigned HOLD_FRAMES = HOLD_FRAMES_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  display_share_ctrl_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  logic        tick;
  logic        boundary;

  disp_state_e state_q, state_d;
  digit_idx_t  idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [15:0] snap_digits_q, snap_digits_d;
  logic [3:0]  snap_blank_q, snap_blank_d;
  logic [3:0]  anodes_q, anodes_d;
  logic [3:0]  hex_q, hex_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        frame_done_q, frame_done_d;

  scan_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Slot 3 is the last of a frame, so the tick leaving it starts a new frame.
  assign boundary = tick && (idx_q == digit_idx_t'(3));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: ownership only changes on a frame boundary.
  always_comb begin
    state_d = state_q;
    if (boundary) begin
      case (state_q)
        IDLE: begin
          if (bus.req_a) begin
            state_d = OWN_A;
          end else if (bus.req_b) begin
            state_d = OWN_B;
          end
        end
        OWN_A: begin
          if (!bus.req_a) begin
            state_d = bus.req_b ? OWN_B : IDLE;
          end else if (bus.req_b && (hold_q >= HoldMax)) begin
            state_d = OWN_B;
          end
        end
        OWN_B: begin
          if (!bus.req_b) begin
            state_d = bus.req_a ? OWN_A : IDLE;
          end else if (bus.req_a && (hold_q >= HoldMax)) begin
            state_d = OWN_A;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Slot index, hold counter and frame snapshot.
  always_comb begin
    idx_d         = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;
    hold_d        = hold_q;
    snap_digits_d = snap_digits_q;
    snap_blank_d  = snap_blank_q;
    if (boundary) begin
      case (state_d)
        OWN_A: begin
          snap_digits_d = bus.digits_a;
          snap_blank_d  = bus.blank_a;
        end
        OWN_B: begin
          snap_digits_d = bus.digits_b;
          snap_blank_d  = bus.blank_b;
        end
        default: begin
          snap_digits_d = '0;
          snap_blank_d  = ANODES_OFF;
        end
      endcase

      if (state_d == IDLE) begin
        hold_d = '0;
      end else if (state_d != state_q) begin
        hold_d = HoldW'(1);
      end else if (hold_q < HoldMax) begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  // FSM outputs. Uses the *_d snapshot so slot 0 shows the frame just captured.
  always_comb begin
    anodes_d     = anodes_q;
    hex_d        = hex_q;
    gnt_a_d      = gnt_a_q;
    gnt_b_d      = gnt_b_q;
    frame_done_d = boundary;
    if (tick) begin
      anodes_d = anode_sel(idx_d);
      if (!bus.en || snap_blank_d[idx_d] || (state_d == IDLE)) begin
        anodes_d = ANODES_OFF;
      end
      hex_d = snap_digits_d[4*idx_d +: 4];
    end
    if (boundary) begin
      gnt_a_d = (state_d == OWN_A);
      gnt_b_d = (state_d == OWN_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= digit_idx_t'(3);
      hold_q        <= '0;
      snap_digits_q <= '0;
      snap_blank_q  <= '0;
      anodes_q      <= ANODES_OFF;
      hex_q         <= '0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      snap_digits_q <= snap_digits_d;
      snap_blank_q  <= snap_blank_d;
      anodes_q      <= anodes_d;
      hex_q         <= hex_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.anodes     = anodes_q;
  assign bus.hex_cur    = hex_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_share_ctrl.sv
// Bench for display_share_ctrl with REFRESH_DIV=4, HOLD_FRAMES=2: directed
// scenarios with literal expectations, then randomized traffic, all checked
// every cycle against a frame-level reference model.
module tb_display_share_ctrl;

  localparam int DIV  = 4;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_share_ctrl_if bus ();

  display_share_ctrl #(
    .REFRESH_DIV(DIV),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  // n counts clock edges since reset; every DIV-th edge is a tick; ticks are
  // numbered from 1 and tick t shows slot (t-1)%4, slot 0 opening a frame.
  int          n = 0;
  int          m_owner = 0;  // 0 none, 1 A, 2 B
  int          m_held = 0;   // frames shown by the current owner so far
  logic [15:0] m_dig = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  e_an = 4'hF;
  logic [3:0]  e_hex = '0;
  logic        e_ga = 1'b0, e_gb = 1'b0, e_fd = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        n = 0; m_owner = 0; m_held = 0; m_dig = '0; m_blank = '0;
        e_an = 4'hF; e_hex = '0; e_ga = 0; e_gb = 0; e_fd = 0;
      end else begin
        n++;
        e_fd = 1'b0;
        if (n % DIV == 0) begin
          int t, slot, nxt;
          t = n / DIV;
          slot = (t - 1) % 4;
          if (slot == 0) begin
            nxt = m_owner;
            if (m_owner == 0) nxt = bus.req_a ? 1 : (bus.req_b ? 2 : 0);
            else if (m_owner == 1) begin
              if (!bus.req_a) nxt = bus.req_b ? 2 : 0;
              else if (bus.req_b && m_held >= HOLD) nxt = 2;
            end else begin
              if (!bus.req_b) nxt = bus.req_a ? 1 : 0;
              else if (bus.req_a && m_held >= HOLD) nxt = 1;
            end
            m_held  = (nxt == 0) ? 0 : ((nxt == m_owner) ? m_held + 1 : 1);
            m_owner = nxt;
            m_dig   = (nxt == 1) ? bus.digits_a : ((nxt == 2) ? bus.digits_b : 16'h0);
            m_blank = (nxt == 1) ? bus.blank_a : ((nxt == 2) ? bus.blank_b : 4'hF);
            e_ga = (nxt == 1);
            e_gb = (nxt == 2);
            e_fd = 1'b1;
          end
          e_an = 4'hF;
          if (bus.en && m_owner != 0 && !m_blank[slot]) e_an[slot] = 1'b0;
          e_hex = m_dig[slot*4 +: 4];
        end
      end
    end
  end

  // Per-cycle compare; hex_cur is undefined content while nobody owns a frame.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("anodes", 16'(bus.anodes), 16'(e_an));
      chk("gnt_a", 16'(bus.gnt_a), 16'(e_ga));
      chk("gnt_b", 16'(bus.gnt_b), 16'(e_gb));
      chk("frame_done", 16'(bus.frame_done), 16'(e_fd));
      chk("grant_excl", 16'(bus.gnt_a & bus.gnt_b), 16'h0);
      if (m_owner != 0 || n < DIV) chk("hex_cur", 16'(bus.hex_cur), 16'(e_hex));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input logic ra, input logic rb, input logic [15:0] da,
                          input logic [15:0] db, input logic [3:0] ba, input logic [3:0] bb);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.req_a = ra; bus.req_b = rb;
    bus.digits_a = da; bus.digits_b = db;
    bus.blank_a = ba; bus.blank_b = bb;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Advance to the negedge after the next tick and check the displayed slot.
  task automatic tick_lit(input string tag, input logic [3:0] an, input logic [3:0] hx);
    repeat (DIV) @(negedge clk);
    chk({tag, "_anodes"}, 16'(bus.anodes), 16'(an));
    chk({tag, "_hex"}, 16'(bus.hex_cur), 16'(hx));
  endtask

  initial begin
    bus.en = 1'b1; bus.req_a = 0; bus.req_b = 0;
    bus.digits_a = '0; bus.digits_b = '0; bus.blank_a = '0; bus.blank_b = '0;

    // 1: A alone, full scan order
    do_reset(1, 0, 16'h1234, 16'h0, 4'h0, 4'h0);
    chk("s1_reset_anodes", 16'(bus.anodes), 16'hF);
    tick_lit("s1_t1", 4'hE, 4'h4);
    chk("s1_gnt_a", 16'(bus.gnt_a), 16'h1);
    chk("s1_fd", 16'(bus.frame_done), 16'h1);
    @(negedge clk);
    chk("s1_fd_low", 16'(bus.frame_done), 16'h0);
    repeat (DIV - 1) @(negedge clk);
    chk("s1_t2_anodes", 16'(bus.anodes), 16'hD);
    chk("s1_t2_hex", 16'(bus.hex_cur), 16'h3);
    tick_lit("s1_t3", 4'hB, 4'h2);
    tick_lit("s1_t4", 4'h7, 4'h1);
    tick_lit("s1_t5", 4'hE, 4'h4);

    // 2: contested, HOLD_FRAMES each
    do_reset(1, 1, 16'hAAAA, 16'hBBBB, 4'h0, 4'h0);
    for (int f = 1; f <= 6; f++) begin
      logic own_a;
      own_a = (f <= 2) || (f >= 5);
      repeat ((f == 1) ? DIV : 4 * DIV) @(negedge clk);
      chk("s2_gnt_a", 16'(bus.gnt_a), 16'(own_a));
      chk("s2_gnt_b", 16'(bus.gnt_b), 16'(!own_a));
      chk("s2_hex", 16'(bus.hex_cur), own_a ? 16'hA : 16'hB);
    end

    // 3: digits change mid-frame do not tear
    do_reset(1, 0, 16'h1234, 16'h0, 4'h0, 4'h0);
    tick_lit("s3_s0", 4'hE, 4'h4);
    tick_lit("s3_s1", 4'hD, 4'h3);
    bus.digits_a = 16'h5678;
    tick_lit("s3_s2", 4'hB, 4'h2);
    tick_lit("s3_s3", 4'h7, 4'h1);
    tick_lit("s3_n0", 4'hE, 4'h8);
    tick_lit("s3_n1", 4'hD, 4'h7);
    tick_lit("s3_n2", 4'hB, 4'h6);
    tick_lit("s3_n3", 4'h7, 4'h5);

    // 4: per-digit blank, then display disabled
    do_reset(1, 0, 16'h1234, 16'h0, 4'b1000, 4'h0);
    tick_lit("s4_s0", 4'hE, 4'h4);
    tick_lit("s4_s1", 4'hD, 4'h3);
    tick_lit("s4_s2", 4'hB, 4'h2);
    tick_lit("s4_s3", 4'hF, 4'h1);
    bus.en = 1'b0;
    tick_lit("s4_off0", 4'hF, 4'h4);
    chk("s4_off_gnt", 16'(bus.gnt_a), 16'h1);
    chk("s4_off_fd", 16'(bus.frame_done), 16'h1);
    tick_lit("s4_off1", 4'hF, 4'h3);
    bus.en = 1'b1;

    // 5: request dropped mid-frame
    do_reset(1, 0, 16'h1234, 16'h0, 4'h0, 4'h0);
    tick_lit("s5_s0", 4'hE, 4'h4);
    tick_lit("s5_s1", 4'hD, 4'h3);
    bus.req_a = 1'b0;
    tick_lit("s5_s2", 4'hB, 4'h2);
    chk("s5_gnt_held", 16'(bus.gnt_a), 16'h1);
    tick_lit("s5_s3", 4'h7, 4'h1);
    repeat (DIV) @(negedge clk);
    chk("s5_gnt_a_off", 16'(bus.gnt_a), 16'h0);
    chk("s5_gnt_b_off", 16'(bus.gnt_b), 16'h0);
    chk("s5_idle_anodes", 16'(bus.anodes), 16'hF);
    chk("s5_idle_fd", 16'(bus.frame_done), 16'h1);

    // 6: asynchronous reset mid-frame while B owns
    do_reset(0, 1, 16'h0, 16'h1234, 4'h0, 4'h0);
    repeat (DIV) @(negedge clk);
    chk("s6_gnt_b", 16'(bus.gnt_b), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_anodes", 16'(bus.anodes), 16'hF);
    chk("s6_rst_gnt_b", 16'(bus.gnt_b), 16'h0);
    chk("s6_rst_hex", 16'(bus.hex_cur), 16'h0);
    chk("s6_rst_fd", 16'(bus.frame_done), 16'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick_lit("s6_after", 4'hE, 4'h4);
    chk("s6_after_gnt_b", 16'(bus.gnt_b), 16'h1);

    // Randomized traffic against the model
    do_reset(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 4'h0, 4'h0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(0, 39) == 0) bus.req_b = ~bus.req_b;
      if ($urandom_range(0, 7) == 0) bus.digits_a = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus.digits_b = 16'($urandom);
      if ($urandom_range(0, 49) == 0) bus.blank_a = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.blank_b = 4'($urandom);
      if ($urandom_range(0, 99) == 0) bus.en = ~bus.en;
      if (i == 2000) begin
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_share_ctrl.md
Name: display_share_ctrl

Overview:
Scan sequencer and two-client arbiter for the 4-digit 7-segment display. Two requesters compete for the display: A is the primary application and B is debug/status. The block grants one client per frame and snapshots that client's four hex digits at the frame boundary so digits never tear mid-frame. It then multiplexes the anodes and drives the current hex nibble to the downstream sevenSeg decoder.

Parameters:
REFRESH_DIV, 208333, clk cycles per digit slot (120 Hz frame at 100 MHz); minimum 2.
HOLD_FRAMES, 30, frames a contested owner keeps the display before yielding; minimum 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  display enable, active high
req_a  in  1  client A requests display (level)
digits_a  in  16  client A digits; [3:0] = rightmost digit
blank_a  in  4  client A per-digit blank, 1 = digit off
req_b  in  1  client B request (level)
digits_b  in  16  client B digits
blank_b  in  4  client B per-digit blank
gnt_a  out  1  A owns current frame
gnt_b  out  1  B owns current frame
anodes  out  4  active-low digit enables; bit0 = rightmost (4'hE)
hex_cur  out  4  nibble for the active digit, to sevenSeg
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values: anodes 4'hF, hex_cur 0, gnt_a/gnt_b 0, frame_done 0, state IDLE, slot index 3, prescaler 0, hold_cnt 0, snapshots 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick = 1 for one cycle when count == REFRESH_DIV-1.
- On tick, slot index advances 3->0->1->2->3. A tick taken while index==3 is a frame boundary. The first tick after reset is therefore a boundary.
- frame_done is registered and is 1 for exactly the cycle after a boundary tick.
- States: IDLE, OWN_A, OWN_B. Transitions are evaluated only on boundary ticks:
  - IDLE: req_a -> OWN_A; else req_b -> OWN_B; else stay.
  - OWN_A:
    - !req_a: req_b -> OWN_B, else IDLE.
    - req_a & req_b & hold_cnt>=HOLD_FRAMES: -> OWN_B.
    - otherwise stay.
  - OWN_B: symmetric to OWN_A. !req_b falls to OWN_A or IDLE; contested with hold satisfied -> OWN_A.
- hold_cnt:
  - Set to 1 on any entry into OWN_A/OWN_B.
  - Incremented, saturating at HOLD_FRAMES, on a boundary where the owner is kept.
  - Cleared in IDLE.
- Net contested behaviour: each owner shows exactly HOLD_FRAMES frames before yielding.
- Snapshot: on the boundary tick, snap_digits/snap_blank load from the next-state owner. In IDLE, snap_blank is 4'hF. Client inputs are ignored between boundaries.
- gnt_a/gnt_b are registered from the next state on the boundary tick and are never both 1.
- On every tick (registered, one-cycle latency from tick):
  - anodes = ~(1<<idx_next), with the bit forced 1 if en==0, snap_blank[idx_next]==1, or next state is IDLE.
  - hex_cur = snap_digits[4*idx_next +: 4].
  - Slot 0 of a frame uses the snapshot taken on that same boundary.
- en=0 only blanks anodes. Scanning, arbitration and grants continue.
- Request drop mid-frame: display and grant persist until the next boundary.
- Simultaneous first requests from IDLE: A wins.
- Reset mid-frame: all state returns to reset values immediately (asynchronous).

Decomposition:
- Package disp_pkg holds:
  - state enum {IDLE, OWN_A, OWN_B}
  - ANODES_OFF = 4'hF
  - digit index type (2-bit)
  - default REFRESH_DIV/HOLD_FRAMES constants.
- One sub-module, scan_tick_gen: parameterised prescaler producing the tick. The arbiter, snapshot and anode logic stay in display_share_ctrl.
- sevenSeg decoding stays downstream.

Test Plan:
All scenarios use REFRESH_DIV=4, HOLD_FRAMES=2, en=1 unless stated.
1. req_a=1 from reset, digits_a=16'h1234, blank_a=0.
   -> First tick: gnt_a=1, anodes=E, hex_cur=4, frame_done pulse.
   -> Subsequent ticks: D/3, B/2, 7/1, then E/4 repeating.
2. req_a=req_b=1 held.
   -> gnt_a for frames 1-2, gnt_b for frames 3-4, gnt_a for frames 5-6.
   -> hex_cur follows digits_a=16'hAAAA / digits_b=16'hBBBB accordingly.
3. Owning A, change digits_a from 16'h1234 to 16'h5678 at slot 1.
   -> Remaining slots show 3,2,1.
   -> Next frame shows 8,7,6,5.
4. blank_a=4'b1000: anodes sequence E,D,B,F. Then en=0: anodes stay F while gnt_a remains 1 and frame_done keeps pulsing.
5. Owning A with req_b=0, drop req_a mid-frame.
   -> Frame completes normally.
   -> Next boundary: gnt_a=0, state IDLE, anodes F.
6. Assert rst_n=0 mid-frame while owning B.
   -> Immediately: anodes=F, gnt_b=0, hex_cur=0, frame_done=0.
   -> After release with req_b=1: gnt_b=1 at first tick.
